// File: rtl/add_share_pkg.sv
// rtl/add_share_pkg.sv - shared constants, unit slot type and round-robin helper
package add_share_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 64;
    localparam int NUNITS    = 2;

    // Tag and operand fields are sized for the largest legal configuration
    // (8 requesters, 128-bit operands); unused upper bits stay zero.
    localparam int TAGW      = 3;
    localparam int RMAX      = 1 << TAGW;
    localparam int SLOT_WMAX = 128;

    typedef struct packed {
        logic                 valid;
        logic [TAGW-1:0]      tag;
        logic [SLOT_WMAX-1:0] a;
        logic [SLOT_WMAX-1:0] b;
    } unit_slot_t;

    function automatic logic [TAGW-1:0] rr_next(input logic [TAGW-1:0] idx, input int n);
        return (int'(idx) + 1 >= n) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - rotating-priority search returning the first two active requesters
module rr_pick2
    import add_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0] req,
    input  logic [TAGW-1:0] ptr,
    output logic            first_vld,
    output logic [TAGW-1:0] first_idx,
    output logic            second_vld,
    output logic [TAGW-1:0] second_idx
);

    logic [RMAX-1:0] req_x;
    logic [TAGW-1:0] idx;

    always_comb begin
        req_x      = RMAX'(req);
        idx        = ptr;
        first_vld  = 1'b0;
        first_idx  = '0;
        second_vld = 1'b0;
        second_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (req_x[idx]) begin
                if (!first_vld) begin
                    first_vld = 1'b1;
                    first_idx = idx;
                end else if (!second_vld) begin
                    second_vld = 1'b1;
                    second_idx = idx;
                end
            end
            idx = rr_next(idx, NREQ);
        end
    end

endmodule

// File: rtl/add_share_arbiter.sv
// rtl/add_share_arbiter.sv - round-robin scheduler for two shared adders among NREQ requesters
module add_share_arbiter
    import add_share_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNTW  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] in0,
    input  logic [NREQ*WIDTH-1:0] in1,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [NREQ*WIDTH-1:0] rsp_data,
    output logic [CNTW-1:0]       op_count
);

    logic [TAGW-1:0]         ptr_q, ptr_d;
    logic                    first_vld, second_vld;
    logic [TAGW-1:0]         first_idx, second_idx;
    logic                    grant_en;
    unit_slot_t [NUNITS-1:0] slot_q, slot_d;
    logic [NREQ*WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [CNTW-1:0]         op_count_q, op_count_d;
    logic [1:0]              n_gnt;
    logic [CNTW:0]           cnt_sum;

    function automatic logic [WIDTH-1:0] pick_op(input logic [NREQ*WIDTH-1:0] bus,
                                                 input logic [TAGW-1:0] sel);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == TAGW'(i)) r = bus[i*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    rr_pick2 #(.NREQ(NREQ)) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .first_vld  (first_vld),
        .first_idx  (first_idx),
        .second_vld (second_vld),
        .second_idx (second_idx)
    );

    always_comb begin
        grant_en = !rst && !hold;
        gnt      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_en && ((first_vld && first_idx == TAGW'(i)) ||
                             (second_vld && second_idx == TAGW'(i))))
                gnt[i] = 1'b1;
        end
    end

    // Unit 0 always serves the first requester found, unit 1 the second.
    always_comb begin
        slot_d          = '0;
        slot_d[0].valid = grant_en && first_vld;
        slot_d[0].tag   = first_idx;
        slot_d[0].a     = SLOT_WMAX'(pick_op(in0, first_idx));
        slot_d[0].b     = SLOT_WMAX'(pick_op(in1, first_idx));
        slot_d[1].valid = grant_en && second_vld;
        slot_d[1].tag   = second_idx;
        slot_d[1].a     = SLOT_WMAX'(pick_op(in0, second_idx));
        slot_d[1].b     = SLOT_WMAX'(pick_op(in1, second_idx));

        n_gnt = 2'(slot_d[0].valid) + 2'(slot_d[1].valid);

        ptr_d = ptr_q;
        if (slot_d[1].valid)
            ptr_d = rr_next(second_idx, NREQ);
        else if (slot_d[0].valid)
            ptr_d = rr_next(first_idx, NREQ);

        cnt_sum    = {1'b0, op_count_q} + (CNTW+1)'(n_gnt);
        op_count_d = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
    end

    // Adders sit behind the operand latches; a requester not answered this
    // cycle sees its previous sum.
    always_comb begin
        rsp_valid  = '0;
        rsp_data_d = rsp_data_q;
        for (int k = 0; k < NUNITS; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (slot_q[k].valid && slot_q[k].tag == TAGW'(i)) begin
                    rsp_valid[i] = 1'b1;
                    rsp_data_d[i*WIDTH +: WIDTH] = WIDTH'(slot_q[k].a + slot_q[k].b);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            slot_q     <= '0;
            rsp_data_q <= '0;
            op_count_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            slot_q     <= slot_d;
            rsp_data_q <= rsp_data_d;
            op_count_q <= op_count_d;
        end
    end

    assign rsp_data = rsp_data_d;
    assign op_count = op_count_q;

endmodule
